// File: rtl/regfile_pkg.sv
// Shared sizing defaults and FSM encoding for the sequential-clear register file.
package regfile_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_ADDR_BITS = 5;
  localparam int NREGS         = 2 ** DEF_ADDR_BITS;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/register32_clr.sv
// One storage word with a write enable and a synchronous clear; clear wins over write.
module register32_clr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // storage word update
  always_ff @(posedge clk) begin
    if (clr) begin
      q_r <= {WIDTH{1'b0}};
    end else if (we) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/regfile_seqclr.sv
// Two-read/one-write register file that zeroes itself one word per cycle after Reset.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_seqclr
  import regfile_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [ADDR_BITS-1:0] ReadRegister1,
  input  logic [ADDR_BITS-1:0] ReadRegister2,
  input  logic [ADDR_BITS-1:0] WriteRegister,
  input  logic [WIDTH-1:0]     WriteData,
  input  logic                 RegWrite,
  output logic [WIDTH-1:0]     ReadData1,
  output logic [WIDTH-1:0]     ReadData2,
  output logic                 Busy
);

  localparam int num_regs = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] ptr_one  = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] ptr_last = {ADDR_BITS{1'b1}};

  state_t               state_r;
  logic [ADDR_BITS-1:0] ptr_r;
  logic                 busy_r;
  logic [WIDTH-1:0]     regs_s [num_regs];
  logic                 hit1_s;
  logic                 hit2_s;

  // clear sequencer: Reset parks at pointer 1, then one word is zeroed per edge
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= CLEAR;
      ptr_r   <= ptr_one;
      busy_r  <= 1'b1;
    end else begin
      case (state_r)
        CLEAR: begin
          ptr_r <= ptr_r + ptr_one;
          if (ptr_r == ptr_last) begin
            state_r <= READY;
            busy_r  <= 1'b0;
          end else begin
            state_r <= CLEAR;
            busy_r  <= 1'b1;
          end
        end
        READY: begin
          state_r <= READY;
          ptr_r   <= ptr_r;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= CLEAR;
          ptr_r   <= ptr_one;
          busy_r  <= 1'b1;
        end
      endcase
    end
  end

  assign regs_s[0] = {WIDTH{1'b0}};

  for (genvar g = 1; g < num_regs; g++) begin : g_reg
    logic clr_s;
    logic we_s;
    assign clr_s = (state_r == CLEAR) && !Reset && (ptr_r == ADDR_BITS'(g));
    assign we_s  = (state_r == READY) && !Reset && RegWrite &&
                   (WriteRegister == ADDR_BITS'(g));
    register32_clr #(.WIDTH(WIDTH)) u_reg (
      .clk (Clk),
      .clr (clr_s),
      .we  (we_s),
      .d   (WriteData),
      .q   (regs_s[g])
    );
  end

`ifdef REGFILE_BYPASS_EN
  assign hit1_s = (state_r == READY) && RegWrite && (WriteRegister != {ADDR_BITS{1'b0}}) &&
                  (WriteRegister == ReadRegister1);
  assign hit2_s = (state_r == READY) && RegWrite && (WriteRegister != {ADDR_BITS{1'b0}}) &&
                  (WriteRegister == ReadRegister2);
`else
  assign hit1_s = 1'b0;
  assign hit2_s = 1'b0;
`endif

  // read port 1: forced to zero while clearing
  always_comb begin
    ReadData1 = {WIDTH{1'b0}};
    if (busy_r) begin
      ReadData1 = {WIDTH{1'b0}};
    end else if (hit1_s) begin
      ReadData1 = WriteData;
    end else begin
      ReadData1 = regs_s[ReadRegister1];
    end
  end

  // read port 2: forced to zero while clearing
  always_comb begin
    ReadData2 = {WIDTH{1'b0}};
    if (busy_r) begin
      ReadData2 = {WIDTH{1'b0}};
    end else if (hit2_s) begin
      ReadData2 = WriteData;
    end else begin
      ReadData2 = regs_s[ReadRegister2];
    end
  end

  assign Busy = busy_r;

endmodule
